// File: rtl/mem_access_pkg.sv
// Shared widths, request slot type and address-fault rule for the memory-access stage.
package mem_access_pkg;

  localparam int MA_ADDR_W = 11;
  localparam int MA_DATA_W = 32;
  localparam int MA_TAG_W  = 5;
  localparam int MA_STAT_W = 32;

  typedef struct packed {
    logic                we;
    logic                err;
    logic [MA_TAG_W-1:0] tag;
  } mem_req_t;

  // Encoding is {rsp_valid, s1_valid}, so the two valid bits are the state.
  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    S1_ONLY  = 2'b01,
    RSP_ONLY = 2'b10,
    BOTH     = 2'b11
  } occ_state_t;

  // Misaligned, or beyond the last byte of a 2**aw word memory.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_access_stats.sv
// Saturating counters of accepted loads, stores and faulting requests.
module mem_access_stats
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_load,
  input  logic                 inc_store,
  input  logic                 inc_fault,
  output logic [MA_STAT_W-1:0] stat_loads,
  output logic [MA_STAT_W-1:0] stat_stores,
  output logic [MA_STAT_W-1:0] stat_faults
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_faults <= '0;
    end else begin
      if (inc_load && (stat_loads != '1))
        stat_loads <= stat_loads + 1'b1;
      if (inc_store && (stat_stores != '1))
        stat_stores <= stat_stores + 1'b1;
      if (inc_fault && (stat_faults != '1))
        stat_faults <= stat_faults + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: EX request -> sync data memory -> in-order WB response.
// Optional request counters are built when MEM_ACCESS_STATS_EN is defined.
//
// state    | meaning
// EMPTY    | nothing in flight
// S1_ONLY  | request issued to memory, awaiting read data
// RSP_ONLY | response presented to WB, S1 free
// BOTH     | response presented and another request in S1
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = MA_ADDR_W,
  parameter int DATA_W = MA_DATA_W,
  parameter int TAG_W  = MA_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_adrs,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_adrs,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_faults
`endif
);

  occ_state_t        state;
  occ_state_t        state_nxt;
  mem_req_t          s1;
  logic              s1_valid;
  logic              req_err;
  logic              adv;
  logic              acc;
  logic [ADDR_W-1:0] word_adrs;

  assign s1_valid  = state[0];
  assign rsp_valid = state[1];
  assign req_err   = addr_fault(req_addr, ADDR_W);
  assign word_adrs = req_addr[ADDR_W+1:2];

  assign mem_w_adrs  = word_adrs;
  assign mem_r_adrs  = word_adrs;
  assign mem_data_in = req_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:    state_nxt = acc ? S1_ONLY : EMPTY;
      S1_ONLY:  state_nxt = acc ? BOTH : RSP_ONLY;
      RSP_ONLY: state_nxt = acc ? (rsp_ready ? S1_ONLY : BOTH)
                                : (rsp_ready ? EMPTY : RSP_ONLY);
      BOTH:     state_nxt = adv ? (acc ? BOTH : RSP_ONLY) : BOTH;
      default:  state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    adv       = 1'b0;
    req_ready = 1'b0;
    case (state)
      EMPTY, RSP_ONLY: req_ready = 1'b1;
      S1_ONLY: begin
        adv       = 1'b1;
        req_ready = 1'b1;
      end
      BOTH: begin
        adv       = rsp_ready;
        req_ready = rsp_ready;
      end
      default: begin
        adv       = 1'b0;
        req_ready = 1'b0;
      end
    endcase
    if (reset)
      req_ready = 1'b0;
    acc      = req_valid & req_ready;
    mem_w_en = acc &  req_we & ~req_err;
    mem_r_en = acc & ~req_we & ~req_err;
  end

  // A held RSP blocks acceptance, so mem_data_out cannot change under S1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      rsp_we   <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
      rsp_data <= '0;
    end else begin
      if (acc) begin
        s1.we  <= req_we;
        s1.err <= req_err;
        s1.tag <= MA_TAG_W'(req_tag);
      end
      if (adv) begin
        rsp_we   <= s1.we;
        rsp_err  <= s1.err;
        rsp_tag  <= TAG_W'(s1.tag);
        rsp_data <= (s1.we | s1.err) ? '0 : mem_data_out;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  mem_access_stats u_stats (
    .clk        (clk),
    .reset      (reset),
    .inc_load   (acc & ~req_we & ~req_err),
    .inc_store  (acc &  req_we & ~req_err),
    .inc_fault  (acc &  req_err),
    .stat_loads (stat_loads),
    .stat_stores(stat_stores),
    .stat_faults(stat_faults)
  );
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios then random traffic
// against a queue-based response model and a shadow copy of memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_tag;
  logic        mem_w_en;
  logic [10:0] mem_w_adrs;
  logic [31:0] mem_data_in;
  logic        mem_r_en;
  logic [10:0] mem_r_adrs;
  logic [31:0] mem_data_out = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic        rsp_err;
  logic [4:0]  rsp_tag;
  logic [31:0] rsp_data;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_faults;
`endif

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_tag     (req_tag),
    .mem_w_en    (mem_w_en),
    .mem_w_adrs  (mem_w_adrs),
    .mem_data_in (mem_data_in),
    .mem_r_en    (mem_r_en),
    .mem_r_adrs  (mem_r_adrs),
    .mem_data_out(mem_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_we      (rsp_we),
    .rsp_err     (rsp_err),
    .rsp_tag     (rsp_tag),
    .rsp_data    (rsp_data)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_faults (stat_faults)
`endif
  );

  always #5 clk = ~clk;

  // 2048x32 synchronous data memory; unwritten words read a background pattern.
  logic [31:0] tb_mem [0:2047];
  bit          written [0:2047];
  always @(posedge clk) begin
    if (mem_w_en) begin
      tb_mem[mem_w_adrs]  <= mem_data_in;
      written[mem_w_adrs] <= 1'b1;
    end
    if (mem_r_en)
      mem_data_out <= written[mem_r_adrs] ? tb_mem[mem_r_adrs] : bg_word(mem_r_adrs);
  end

  function automatic logic [31:0] bg_word(input logic [10:0] a);
    return 32'hA500_0000 | {21'd0, a};
  endfunction

  typedef struct {
    logic        we;
    logic        err;
    logic [4:0]  tag;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:2047];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          m_loads  = 0;
  int          m_stores = 0;
  int          m_faults = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_tag   = tag;
  endtask

  // One cycle: sample at negedge, compare against the model, then advance past the edge.
  task automatic step();
    exp_t        e;
    logic        acc;
    logic        err;
    logic [10:0] wa;
    @(negedge clk);
    // Capacity two; the oldest entry is visible two cycles after acceptance.
    check("req_ready", {31'd0, req_ready}, {31'd0, (q.size() < 2) || rsp_ready});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, (q.size() > 0) && (cyc >= q[0].cyc + 2)});
    if (rsp_valid && q.size() > 0) begin
      check("rsp_we",   {31'd0, rsp_we},  {31'd0, q[0].we});
      check("rsp_err",  {31'd0, rsp_err}, {31'd0, q[0].err});
      check("rsp_tag",  {27'd0, rsp_tag}, {27'd0, q[0].tag});
      check("rsp_data", rsp_data, q[0].data);
      if (rsp_ready)
        void'(q.pop_front());
    end
    acc = req_valid && req_ready;
    err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'h0000_2000);
    wa  = req_addr[12:2];
    check("mem_w_en", {31'd0, mem_w_en}, {31'd0, acc && req_we && !err});
    check("mem_r_en", {31'd0, mem_r_en}, {31'd0, acc && !req_we && !err});
    if (acc && !err && req_we) begin
      check("mem_w_adrs",  {21'd0, mem_w_adrs}, {21'd0, wa});
      check("mem_data_in", mem_data_in, req_wdata);
    end
    if (acc && !err && !req_we)
      check("mem_r_adrs", {21'd0, mem_r_adrs}, {21'd0, wa});
    if (acc) begin
      e.we   = req_we;
      e.err  = err;
      e.tag  = req_tag;
      e.data = (err || req_we) ? 32'd0 : ref_mem[wa];
      e.cyc  = cyc;
      q.push_back(e);
      if (err) m_faults++;
      else if (req_we) begin
        m_stores++;
        ref_mem[wa] = req_wdata;
      end else m_loads++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int unsigned r;
    for (int i = 0; i < 2048; i++) ref_mem[i] = bg_word(11'(i));

    reset     = 1'b1;
    rsp_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h10, 32'd0, 5'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_r_en",  {31'd0, mem_r_en},  32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_tag",   {27'd0, rsp_tag}, 32'd0);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    reset = 1'b0;

    // Store then load same word, rsp_ready high
    set_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 5'd3); step();
    set_req(1'b1, 1'b0, 32'h10, 32'd0,        5'd4); step();
    set_req(1'b0, 1'b0, 32'd0,  32'd0,        5'd0);
    repeat (3) step();

    // Back-to-back loads with WB stalled for three cycles
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 32'h0, 32'd0, 5'd10); step();
    set_req(1'b1, 1'b0, 32'h4, 32'd0, 5'd11); step();
    set_req(1'b1, 1'b0, 32'h8, 32'd0, 5'd12); step();
    rsp_ready = 1'b1;
    step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (4) step();

    // Misaligned and out-of-range
    set_req(1'b1, 1'b0, 32'h12,   32'd0, 5'd20); step();
    set_req(1'b1, 1'b0, 32'h2000, 32'd0, 5'd21); step();
    set_req(1'b1, 1'b1, 32'h2004, 32'h1234, 5'd22); step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (3) step();

    // Last word
    set_req(1'b1, 1'b1, 32'h1FFC, 32'hCAFEF00D, 5'd30); step();
    set_req(1'b1, 1'b0, 32'h1FFC, 32'd0,        5'd31); step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (3) step();

    // Reset with S1 and RSP both full
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 32'h0, 32'd0, 5'd5); step();
    set_req(1'b1, 1'b0, 32'h4, 32'd0, 5'd6); step();
    set_req(1'b1, 1'b0, 32'h8, 32'd0, 5'd7);
    reset = 1'b1;
    #1;
    check("rst_full_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_full_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_full_mem_r_en",  {31'd0, mem_r_en},  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_loads = 0; m_stores = 0; m_faults = 0;
    rsp_ready = 1'b1;
    set_req(1'b1, 1'b1, 32'h10, 32'h0BADF00D, 5'd8); step();
    set_req(1'b1, 1'b0, 32'h10, 32'd0,        5'd9); step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (3) step();

    // Random traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = ({21'd0, 11'($urandom_range(0, 2047))} << 2) + $urandom_range(1, 3);
      else if (r == 1) a = 32'h2000 + ($urandom_range(0, 255) << 2);
      else if (r == 2) a = 32'h1FFC;
      else             a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      set_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
              $urandom, 5'($urandom_range(0, 31)));
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
    check("drain_outstanding", 32'(q.size()), 32'd0);

`ifdef MEM_ACCESS_STATS_EN
    check("stat_loads",  stat_loads,  32'(m_loads));
    check("stat_stores", stat_stores, 32'(m_stores));
    check("stat_faults", stat_faults, 32'(m_faults));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
